// File: rtl/fifo_burst_pkg.sv
// Shared types and sizing helpers for the FIFO burst scheduler.
package fifo_burst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } state_e;

  // Count ports carry one extra bit so a completely full FIFO is representable.
  function automatic int cnt_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic int timer_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/burst_out_reg.sv
// One-entry registered valid/ready output stage carrying the burst beat data and last flag.
module burst_out_reg #(
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_dat,
  input  logic                  load_last,
  input  logic                  m_rdy,
  output logic                  m_vld,
  output logic [DATA_WIDTH-1:0] m_dat,
  output logic                  m_last
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_vld  <= 1'b0;
      // NOTE: the data register is reset too, because its zero reset value is visible on the port.
      m_dat  <= '0;
      m_last <= 1'b0;
    end else if (load) begin
      m_vld  <= 1'b1;
      m_dat  <= load_dat;
      m_last <= load_last;
    end else if (m_vld && m_rdy) begin
      m_vld  <= 1'b0;
      m_last <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_burst_scheduler.sv
// Read-side burst sequencer for the FWFT FIFO: requests a burst, then drains it on grant.
// Define FIFO_BURST_TIMEOUT_EN to flush partial bursts after TIMEOUT_CYCLES idle cycles.
module fifo_burst_scheduler
  import fifo_burst_pkg::*;
#(
  parameter int DATA_WIDTH     = 128,
  parameter int ADDR_WIDTH     = 8,
  parameter int BURST_LEN      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rstn,
  output logic                  fifo_rd_ena,
  input  logic [DATA_WIDTH-1:0] fifo_rd_dat,
  input  logic                  fifo_rd_empty,
  input  logic [ADDR_WIDTH:0]   fifo_rd_dat_cnt,
  output logic                  burst_req,
  output logic [ADDR_WIDTH:0]   burst_len,
  input  logic                  burst_ack,
  output logic                  m_vld,
  output logic [DATA_WIDTH-1:0] m_dat,
  output logic                  m_last,
  input  logic                  m_rdy,
  output logic                  busy
);

  localparam int               CNT_W    = cnt_width(ADDR_WIDTH);
  localparam logic [CNT_W-1:0] FULL_LEN = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_e           state;
  logic [CNT_W-1:0] pop_cnt;
  logic             full_hit;
  logic             timeout_hit;
  logic             start;
  logic [CNT_W-1:0] start_len;

  // Full-width compare: a full FIFO sets the count MSB and must still qualify.
  assign full_hit  = (fifo_rd_dat_cnt >= FULL_LEN);
  assign start     = full_hit || timeout_hit;
  assign start_len = full_hit ? FULL_LEN : fifo_rd_dat_cnt;

  assign burst_req   = (state == ST_REQ);
  assign busy        = (state != ST_IDLE);
  assign fifo_rd_ena = (state == ST_XFER) && (pop_cnt != '0) && !fifo_rd_empty
                       && (!m_vld || m_rdy);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      pop_cnt   <= '0;
      burst_len <= '0;
    end else begin
      // NOTE: non-blocking assignments let every register here sample pre-edge values.
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_REQ;
            burst_len <= start_len;
            pop_cnt   <= start_len;
          end
        end
        ST_REQ: begin
          if (burst_ack) state <= ST_XFER;
        end
        ST_XFER: begin
          if (fifo_rd_ena) pop_cnt <= pop_cnt - ONE;
          if (m_vld && m_rdy && m_last) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FIFO_BURST_TIMEOUT_EN
  localparam int               TMR_W   = timer_width(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYCLES);

  logic [TMR_W-1:0] idle_cnt;
  logic             partial;

  // A full burst wins over a flush because full_hit masks the partial condition.
  assign partial     = (state == ST_IDLE) && (fifo_rd_dat_cnt != '0) && !full_hit;
  assign timeout_hit = partial && (idle_cnt == TMR_MAX);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idle_cnt <= '0;
    end else if (partial && (idle_cnt != TMR_MAX)) begin
      idle_cnt <= idle_cnt + TMR_W'(1);
    end else begin
      idle_cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  burst_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .rstn     (rstn),
    .load     (fifo_rd_ena),
    .load_dat (fifo_rd_dat),
    .load_last(pop_cnt == ONE),
    .m_rdy    (m_rdy),
    .m_vld    (m_vld),
    .m_dat    (m_dat),
    .m_last   (m_last)
  );

endmodule

// File: tb/tb_fifo_burst_scheduler.sv
// Scoreboard bench for fifo_burst_scheduler: FIFO model, auto-acking consumer, decoupled beat monitor.
`timescale 1ns/1ps
module tb_fifo_burst_scheduler;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int BL = 8;
  localparam int TO = 8;
  localparam int CW = AW + 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic          fifo_rd_ena;
  logic [DW-1:0] fifo_rd_dat;
  logic          fifo_rd_empty;
  logic [AW:0]   fifo_rd_dat_cnt;
  logic          burst_req;
  logic [AW:0]   burst_len;
  logic          burst_ack;
  logic          m_vld;
  logic [DW-1:0] m_dat;
  logic          m_last;
  logic          m_rdy;
  logic          busy;

  fifo_burst_scheduler #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .BURST_LEN     (BL),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .fifo_rd_ena    (fifo_rd_ena),
    .fifo_rd_dat    (fifo_rd_dat),
    .fifo_rd_empty  (fifo_rd_empty),
    .fifo_rd_dat_cnt(fifo_rd_dat_cnt),
    .burst_req      (burst_req),
    .burst_len      (burst_len),
    .burst_ack      (burst_ack),
    .m_vld          (m_vld),
    .m_dat          (m_dat),
    .m_last         (m_last),
    .m_rdy          (m_rdy),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] dat;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  int            len_q[$];
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] sent_q[$];

  int checks    = 0;
  int errors    = 0;
  int pop_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_fifo();
    fifo_rd_empty   = (fifo_q.size() == 0);
    fifo_rd_dat     = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    fifo_rd_dat_cnt = CW'(fifo_q.size());
  endtask

  task automatic write_words(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(base + DW'(i));
      sent_q.push_back(base + DW'(i));
    end
    drive_fifo();
  endtask

  // Next n words written become one expected burst; last marks the final beat.
  task automatic expect_burst(input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.dat  = sent_q.pop_front();
      b.last = (i == n - 1);
      exp_q.push_back(b);
    end
    len_q.push_back(n);
  endtask

  // FIFO model: pop on the edge where the DUT strobed, then present the new head.
  always @(posedge clk) begin : fifo_model
    logic          pop_s;
    logic [DW-1:0] junk;
    pop_s = fifo_rd_ena;
    #1;
    if (pop_s === 1'b1) begin
      check("pop_nonempty", fifo_q.size() != 0, 1);
      if (fifo_q.size() != 0) junk = fifo_q.pop_front();
      pop_total++;
    end
    drive_fifo();
  end

  // Consumer grant: ack the third cycle burst_req is seen, checking the advertised length.
  int req_age = 0;
  always @(negedge clk) begin
    if (rstn !== 1'b1) begin
      burst_ack = 1'b0;
      req_age   = 0;
    end else if (burst_ack) begin
      burst_ack = 1'b0;
    end else if (burst_req) begin
      req_age++;
      if (req_age >= 3) begin
        check("req_expected", len_q.size() != 0, 1);
        if (len_q.size() != 0) check("burst_len", burst_len, len_q.pop_front());
        burst_ack = 1'b1;
        req_age   = 0;
      end
    end
  end

  bit rdy_toggle = 0;
  int rdy_phase  = 0;
  always @(posedge clk) begin
    #2;
    if (rdy_toggle) begin
      m_rdy     = (rdy_phase == 0) || (rdy_phase == 3);
      rdy_phase = (rdy_phase + 1) % 4;
    end else begin
      m_rdy = 1'b1;
    end
  end

  // Monitor: compare every accepted beat against the scoreboard and police stalls.
  beat_t         mon_e;
  bit            was_stalled = 0;
  bit            after_last  = 0;
  logic [DW-1:0] stall_dat;
  logic          stall_last;
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (after_last) begin
        check("busy_after_last", busy, 0);
        check("vld_after_last", m_vld, 0);
        after_last = 0;
      end
      if (was_stalled) begin
        check("hold_vld", m_vld, 1);
        check("hold_dat", m_dat, stall_dat);
        check("hold_last", m_last, stall_last);
      end
      was_stalled = m_vld && !m_rdy;
      if (was_stalled) begin
        stall_dat  = m_dat;
        stall_last = m_last;
        check("no_pop_stall", fifo_rd_ena, 0);
      end
      if (m_vld && m_rdy) begin
        check("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("beat_dat", m_dat, mon_e.dat);
          check("beat_last", m_last, mon_e.last);
        end
        if (m_last) after_last = 1;
      end
    end else begin
      was_stalled = 0;
      after_last  = 0;
    end
  end

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || len_q.size() != 0 || busy || burst_req) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, n < budget, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_ena"}, fifo_rd_ena, 0);
    check({tag, "_req"}, burst_req, 0);
    check({tag, "_len"}, burst_len, 0);
    check({tag, "_vld"}, m_vld, 0);
    check({tag, "_dat"}, m_dat, 0);
    check({tag, "_last"}, m_last, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin : stimulus
    int  p0;
    bit  found;
    rstn      = 1'b1;
    burst_ack = 1'b0;
    m_rdy     = 1'b1;
    drive_fifo();
    #1 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("rst");
    @(posedge clk);
    #2 rstn = 1'b1;

    // Words trickle in one per cycle; request follows the count reaching BURST_LEN.
    for (int i = 0; i < BL; i++) begin
      @(posedge clk);
      #2 write_words(1, 32'h100 + DW'(i));
      if (i == BL - 2) begin
        @(negedge clk);
        check("t1_no_req_early", burst_req, 0);
      end
    end
    expect_burst(BL);
    @(negedge clk);
    check("t1_req_pre", burst_req, 0);
    @(negedge clk);
    check("t1_req", burst_req, 1);
    check("t1_len", burst_len, BL);
    check("t1_busy", busy, 1);
    wait_drain("t1", 60);

    // Consumer backpressure 1,0,0,1 during a burst.
    @(posedge clk);
    rdy_toggle = 1;
    p0 = pop_total;
    #2 write_words(BL, 32'h200);
    expect_burst(BL);
    wait_drain("t2", 120);
    check("t2_pops", pop_total - p0, BL);
    rdy_toggle = 0;

    // 20 preloaded words give two back-to-back bursts and a 4-word remainder.
    @(posedge clk);
    p0 = pop_total;
    #2 write_words(20, 32'h300);
    expect_burst(BL);
    expect_burst(BL);
`ifdef FIFO_BURST_TIMEOUT_EN
    expect_burst(4);
    wait_drain("t3", 200);
    check("t3_pops", pop_total - p0, 20);
`else
    wait_drain("t3", 120);
    repeat (30) @(negedge clk);
    check("t3_no_req", burst_req, 0);
    check("t3_idle", busy, 0);
    check("t3_left", fifo_rd_dat_cnt, 4);
    check("t3_pops", pop_total - p0, 16);
`endif

    // FIFO jumps to completely full: count MSB set, must not look like zero.
    @(posedge clk);
    p0 = pop_total;
`ifdef FIFO_BURST_TIMEOUT_EN
    #2 write_words(16, 32'h400);
`else
    #2 write_words(12, 32'h400);
`endif
    check("t4_cnt_full", fifo_rd_dat_cnt, 16);
    expect_burst(BL);
    expect_burst(BL);
    @(negedge clk);
    @(negedge clk);
    check("t4_req_full", burst_req, 1);
    check("t4_len_full", burst_len, BL);
    wait_drain("t4", 150);
    check("t4_pops", pop_total - p0, 16);

    // Reset while beat 7 is on the output; 9 unpopped words are rescheduled.
    @(posedge clk);
    #2 write_words(16, 32'h500);
    expect_burst(BL);
    found = 0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      if (m_vld && m_dat == 32'h506) found = 1;
    end
    check("t5_beat7_seen", found, 1);
    #1 rstn = 1'b0;
    #1 check_all_zero("t5_rst");
    exp_q.delete();
    len_q.delete();
    sent_q.push_front(32'h507);
    check("t5_left", fifo_rd_dat_cnt, 9);
    repeat (2) @(posedge clk);
    expect_burst(BL);
`ifdef FIFO_BURST_TIMEOUT_EN
    expect_burst(1);
`endif
    #2 rstn = 1'b1;
    wait_drain("t5", 150);
`ifdef FIFO_BURST_TIMEOUT_EN
    check("t5_left_after", fifo_rd_dat_cnt, 0);
`else
    check("t5_left_after", fifo_rd_dat_cnt, 1);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_burst_scheduler.md
# fifo_burst_scheduler

Read-side sequencer for the width-adapting first-word-fall-through FIFO. It watches the FIFO fill count and requests a burst from a downstream consumer (DMA or bus master) once BURST_LEN words are available. After the grant it drains exactly that many words through a registered valid/ready stream, marking the final beat with last. It sits between the FIFO read port and the burst-oriented consumer, and is the only agent popping the FIFO.

## Interface
- DATA_WIDTH, 128, FIFO read word width
- ADDR_WIDTH, 8, FIFO depth 2**ADDR_WIDTH; count port is ADDR_WIDTH+1 bits
- BURST_LEN, 16, words per full burst; legal range 1..2**ADDR_WIDTH
- TIMEOUT_CYCLES, 1024, idle cycles before a partial flush (only with the timeout feature)

Ports:
- clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- fifo_rd_ena  out  1  pop strobe to FIFO
- fifo_rd_dat  in  DATA_WIDTH  FWFT head word, valid while !fifo_rd_empty
- fifo_rd_empty  in  1  FIFO empty
- fifo_rd_dat_cnt  in  ADDR_WIDTH+1  words in FIFO
- burst_req  out  1  burst request, held until acked
- burst_len  out  ADDR_WIDTH+1  words in the requested burst, stable while burst_req or busy
- burst_ack  in  1  one-cycle grant from consumer
- m_vld  out  1  output beat valid
- m_dat  out  DATA_WIDTH  output beat data
- m_last  out  1  final beat of burst
- m_rdy  in  1  consumer ready
- busy  out  1  high from leaving IDLE until the last beat is accepted

## Operation
- FSM states IDLE, REQ, XFER; reset state IDLE.
- IDLE -> REQ when fifo_rd_dat_cnt >= BURST_LEN.
  - On that transition burst_len <= BURST_LEN and pop_cnt <= BURST_LEN.
- REQ: burst_req=1. On burst_ack -> XFER and burst_req drops the same edge. burst_ack outside REQ is ignored.
- XFER pop rule: fifo_rd_ena = (pop_cnt != 0) && !fifo_rd_empty && (!m_vld || m_rdy).
- Each pop loads m_dat <= fifo_rd_dat, sets m_vld=1, decrements pop_cnt, and sets m_last when pop_cnt == 1.
- m_vld clears when a beat is accepted (m_vld && m_rdy) with no new pop that cycle.
- XFER -> IDLE on accepted beat with m_last=1; m_last and m_vld clear, busy drops.
- The scheduler is the sole reader, so the FIFO never runs dry mid-burst. If it does, popping stalls with no error and resumes when data returns.
- Arithmetic: pop_cnt is ADDR_WIDTH+1 bits and never wraps; the compare uses the full count width, so a full FIFO (MSB set) is handled.
- Reset mid-burst: all state cleared immediately. Words already popped are lost. Unpopped words stay in the FIFO and are re-scheduled after reset release.

## Timing
- Reset values: fifo_rd_ena 0, burst_req 0, burst_len 0, m_vld 0, m_dat 0, m_last 0, busy 0.
- Count reaching BURST_LEN -> burst_req high on the next edge (1 cycle).
- burst_ack at edge N -> first fifo_rd_ena in cycle N+1 -> m_vld at N+2.
- With m_rdy held high: one beat per cycle, a BURST_LEN-beat burst occupies BURST_LEN+1 cycles after ack, and the next IDLE evaluation is the cycle after the last accept.
- m_dat, m_last and m_vld are registered and hold while m_vld && !m_rdy.
- fifo_rd_ena is combinational from state, registers, fifo_rd_empty and m_rdy.

## Configuration
- FIFO_BURST_TIMEOUT_EN defined:
  - An idle counter runs in IDLE while 0 < cnt < BURST_LEN and clears otherwise.
  - When the counter reaches TIMEOUT_CYCLES, IDLE -> REQ with burst_len = pop_cnt = fifo_rd_dat_cnt sampled that cycle.
  - A full-burst condition in the same cycle takes priority.
- Undefined: no counter and no partial bursts; words below BURST_LEN wait indefinitely, and TIMEOUT_CYCLES is unused.

## Structure
- Shared package fifo_burst_pkg holds:
  - state enum (IDLE, REQ, XFER);
  - localparam CNT_W = ADDR_WIDTH+1 convention;
  - function clog2-based timer width for TIMEOUT_CYCLES.
- One sub-module, burst_out_reg: the one-entry registered valid/ready output stage carrying m_dat/m_last. The FSM, pop counter and timeout live in the top.

## Test plan
- Count rises 0->16, BURST_LEN=16, ack after 3 cycles, m_rdy=1 -> burst_req high 1 cycle after count=16, burst_len=16, 16 beats in order, m_last only on beat 16, busy low the cycle after.
- m_rdy toggling 1,0,0,1,… during a burst -> m_dat stable while stalled, no pops while m_vld && !m_rdy, exactly 16 pops total.
- 40 words preloaded -> two back-to-back bursts of 16, then IDLE with 8 words left and no request (timeout disabled).
- FIFO_BURST_TIMEOUT_EN, TIMEOUT_CYCLES=8, 5 words then no writes -> burst_req after 8 idle cycles, burst_len=5, m_last on beat 5.
- rstn asserted during beat 7 of 16 -> all outputs 0 asynchronously. After release with 9 words left and BURST_LEN=8 -> new burst of 8.
- Full FIFO, count=256, BURST_LEN=256 -> single 256-beat burst, count width correct, no wrap.
